// File: rtl/stream_mux_rr_pkg.sv
// Shared types and defaults for the stream_mux_rr N-to-1 stream multiplexer.
// The optional packet lock is enabled by defining STREAM_MUX_LOCK_EN.
package stream_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the multiplexer and one consumer.
// STREAM_MUX_LOCK_EN adds the in_last/out_last packet-boundary signals.
interface stream_mux_rr_if #(
   parameter int N = stream_mux_pkg::DEF_N,
   parameter int W = stream_mux_pkg::DEF_W
);
   import stream_mux_pkg::*;

   localparam int SEL_W = $clog2(N);

   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [N*W-1:0]   in_data;
   mode_e            mode;
   logic [SEL_W-1:0] sel;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_chan;
`ifdef STREAM_MUX_LOCK_EN
   logic [N-1:0]     in_last;
   logic             out_last;
`endif

   modport slave (
      input  in_valid, in_data, mode, sel, out_ready,
`ifdef STREAM_MUX_LOCK_EN
      input  in_last,
      output out_last,
`endif
      output in_ready, out_valid, out_data, out_chan
   );

   modport master (
      output in_valid, in_data, mode, sel, out_ready,
`ifdef STREAM_MUX_LOCK_EN
      output in_last,
      input  out_last,
`endif
      input  in_ready, out_valid, out_data, out_chan
   );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester found searching
// upward from ptr_i+1 (wrapping modulo N) wins.
module rr_arbiter #(
   parameter int N = stream_mux_pkg::DEF_N
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 gnt_valid_o,
   output logic [$clog2(N)-1:0] gnt_idx_o
);
   import stream_mux_pkg::*;

   localparam int SEL_W = $clog2(N);

   // Walk the offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      int idx;
      idx         = 0;
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr_i) + k) % N;
         if (req_i[idx]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = SEL_W'(idx);
         end else begin
            gnt_valid_o = gnt_valid_o;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with one registered output stage, fixed or
// round-robin selection; STREAM_MUX_LOCK_EN adds RR packet locking.
module stream_mux_rr #(
   parameter int N = stream_mux_pkg::DEF_N,
   parameter int W = stream_mux_pkg::DEF_W
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_mux_rr_if.slave bus
);
   import stream_mux_pkg::*;

   localparam int SEL_W = $clog2(N);

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;
   logic             arb_valid_s, gnt_valid_s, load_en_s, xfer_s;
   logic [SEL_W-1:0] arb_idx_s,   gnt_idx_s;
   logic [N-1:0]     in_ready_s;
`ifdef STREAM_MUX_LOCK_EN
   logic             lock_q, lock_d;
   logic             out_last_q, out_last_d;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .req_i       (bus.in_valid),
      .ptr_i       (ptr_q),
      .gnt_valid_o (arb_valid_s),
      .gnt_idx_o   (arb_idx_s)
   );

   // Grant select: a locked packet pins the RR grant to the last granted channel.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = '0;
      if (bus.mode == MODE_RR) begin
`ifdef STREAM_MUX_LOCK_EN
         if (lock_q) begin
            gnt_valid_s = bus.in_valid[ptr_q];
            gnt_idx_s   = ptr_q;
         end else begin
            gnt_valid_s = arb_valid_s;
            gnt_idx_s   = arb_idx_s;
         end
`else
         gnt_valid_s = arb_valid_s;
         gnt_idx_s   = arb_idx_s;
`endif
      end else if (int'(bus.sel) < N) begin
         gnt_valid_s = bus.in_valid[bus.sel];
         gnt_idx_s   = bus.sel;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_idx_s   = '0;
      end
   end

   assign load_en_s = !out_valid_q || bus.out_ready;
   assign xfer_s    = load_en_s && gnt_valid_s && rst_n;

   // One-hot ready toward the granted producer.
   always_comb begin
      in_ready_s = '0;
      if (xfer_s) begin
         in_ready_s[gnt_idx_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
   end

   // Next state of the output stage, pointer and packet lock.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
      lock_d      = lock_q;
      out_last_d  = out_last_q;
`endif
      if (xfer_s) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.in_data[int'(gnt_idx_s)*W +: W];
         out_chan_d  = gnt_idx_s;
`ifdef STREAM_MUX_LOCK_EN
         out_last_d  = bus.in_last[gnt_idx_s];
`endif
         if (bus.mode == MODE_RR) begin
            ptr_d = gnt_idx_s;
`ifdef STREAM_MUX_LOCK_EN
            lock_d = !bus.in_last[gnt_idx_s];
`endif
         end else begin
            ptr_d = ptr_q;
         end
      end else if (load_en_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
`ifdef STREAM_MUX_LOCK_EN
      if (bus.mode == MODE_FIXED) begin
         lock_d = 1'b0;
      end else begin
         lock_d = lock_d;
      end
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= SEL_W'(N - 1);
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= 1'b0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= lock_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
`ifdef STREAM_MUX_LOCK_EN
   assign bus.out_last  = out_last_q;
`endif

endmodule
